// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
package cpu_pkg;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HELD    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
  } if_id_t;

  // Sequential successor address; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] next_pc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(PC_STEP);
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush > load > hold-on-stall > consume.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_flush,
  input  logic   i_load,
  input  logic   i_stall,
  input  if_id_t i_data,
  output if_id_t o_q
);
  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q.valid <= 1'b0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (!i_stall) begin
      r_q.valid <= 1'b0;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the imem req/ack handshake, fills IF/ID.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_init,
  input  logic              stall_i,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] program_counter,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc,
  output logic [DATA_W-1:0] if_id_pc_plus4
);
  fetch_state_e      r_state, w_state_nxt;
  logic [DATA_W-1:0] r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_stale_addr, w_stale_nxt;
  logic [DATA_W-1:0] r_hold_instr, w_hold_instr_nxt;
  logic [DATA_W-1:0] r_hold_pc, w_hold_pc_nxt;
  logic              w_load;
  if_id_t            w_load_data;
  if_id_t            w_if_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= pc_init;
      r_stale_addr <= '0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_stale_addr <= w_stale_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_stale_nxt      = r_stale_addr;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_load           = 1'b0;
    w_load_data      = '{valid: 1'b1, instr: imem_rdata, pc: r_pc, pc_plus4: next_pc(r_pc)};
    imem_req         = 1'b0;
    imem_addr        = r_pc;
    case (r_state)
      S_REQ: begin
        imem_req = !rst;
        if (imem_ack) begin
          if (redirect_valid) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = next_pc(r_pc);
            if (!w_if_id.valid || !stall_i) begin
              w_load = 1'b1;
            end else begin
              // Decode is full and stalled: park the word until the slot frees.
              w_hold_instr_nxt = imem_rdata;
              w_hold_pc_nxt    = r_pc;
              w_state_nxt      = S_HELD;
            end
          end
        end else if (redirect_valid) begin
          // Request already in flight: keep its address on the bus until acked.
          w_stale_nxt = r_pc;
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_DISCARD;
        end
      end
      S_HELD: begin
        w_load_data = '{valid: 1'b1, instr: r_hold_instr, pc: r_hold_pc,
                        pc_plus4: next_pc(r_hold_pc)};
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_REQ;
        end else if (!stall_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DISCARD: begin
        imem_req  = !rst;
        imem_addr = r_stale_addr;
        if (redirect_valid) w_pc_nxt = redirect_pc;
        if (imem_ack) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_load  (w_load),
    .i_stall (stall_i),
    .i_data  (w_load_data),
    .o_q     (w_if_id)
  );

  assign program_counter = r_pc;
  assign if_id_valid     = w_if_id.valid;
  assign if_id_instr     = w_if_id.instr;
  assign if_id_pc        = w_if_id.pc;
  assign if_id_pc_plus4  = w_if_id.pc_plus4;
endmodule
